// File: rtl/hx711_pkg.sv
// Shared types and constants for the multi-channel HX711 reader.
// Holds the controller state encoding, the gain-mode encoding, the
// PD_SCK pulse counts per mode and the gain-to-pulse-count mapping.
package hx711_pkg;

  typedef enum logic [2:0] {
    PDOWN    = 3'd0,
    WAIT_RDY = 3'd1,
    SCK_HI   = 3'd2,
    SCK_LO   = 3'd3,
    DONE     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    GAIN_A128 = 2'd0,
    GAIN_B32  = 2'd1,
    GAIN_A64  = 2'd2,
    GAIN_RSVD = 2'd3
  } gain_t;

  localparam logic [4:0] PULSES_A128 = 5'd25;
  localparam logic [4:0] PULSES_B32  = 5'd26;
  localparam logic [4:0] PULSES_A64  = 5'd27;
  localparam logic [4:0] DATA_PULSES = 5'd24;

  // Total PD_SCK pulses for a conversion; the extra pulses past 24 select
  // the gain of the following conversion. The reserved code behaves as A/128.
  function automatic logic [4:0] gain_pulses(input logic [1:0] gain_sel);
    case (gain_t'(gain_sel))
      GAIN_B32: return PULSES_B32;
      GAIN_A64: return PULSES_A64;
      default:  return PULSES_A128;
    endcase
  endfunction

  // Sign-extend a raw 24-bit two's-complement sample to 32 bits.
  function automatic logic signed [31:0] sext24(input logic [23:0] raw);
    return {{8{raw[23]}}, raw};
  endfunction

endpackage

// File: rtl/hx711_chan_shift.sv
// Per-channel datapath: DOUT synchronizer, 24-bit MSB-first capture register
// and, when HX711_AVG_EN is defined, a signed averaging accumulator.
// Without HX711_AVG_EN the captured word is presented directly.
module hx711_chan_shift
  import hx711_pkg::*;
`ifdef HX711_AVG_EN
#(
  parameter int AVG_LOG2 = 2
)
`endif
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               dt,
  input  logic               shift_en,
  input  logic               clear,
`ifdef HX711_AVG_EN
  input  logic               acc_add,
  input  logic               acc_clear,
  input  logic               win_last,
`endif
  output logic               dt_sync,
  output logic signed [31:0] sample
);

  logic [1:0]  sync_ff;
  logic [23:0] shreg;

  // Two-stage synchronizer; DOUT is asynchronous to clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_ff <= '0;
    else          sync_ff <= {sync_ff[0], dt};
  end

  assign dt_sync = sync_ff[1];

  // Capture register; a started or aborted conversion discards partial bits
  always_ff @(posedge clk) begin
    if (clear)         shreg <= '0;
    else if (shift_en) shreg <= {shreg[22:0], dt_sync};
  end

`ifdef HX711_AVG_EN
  localparam int ACC_W = 24 + AVG_LOG2;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;

  assign acc_sum = acc + ACC_W'(signed'(shreg));

  // Running sum over the window; restarts after the window's last sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       acc <= '0;
    else if (acc_clear) acc <= '0;
    else if (acc_add)   acc <= win_last ? '0 : acc_sum;
  end

  // Window average including the sample completing in this DONE cycle
  assign sample = 32'(acc_sum >>> AVG_LOG2);
`else
  assign sample = sext24(shreg);
`endif

endmodule

// File: rtl/hx711_multi_reader.sv
// Multi-channel HX711 reader: one shared PD_SCK drives NUM_CH converters,
// every channel is captured in parallel and a complete sample set is offered
// on a valid/ready output with a sticky overrun flag.
// Optional feature macro: HX711_AVG_EN (average 2^AVG_LOG2 conversions).
module hx711_multi_reader
  import hx711_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int SCK_HALF = 25,
  parameter int AVG_LOG2 = 2
)
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [1:0]            gain_sel,
  input  logic [NUM_CH-1:0]     hx711_dt,
  output logic                  hx711_sck,
  output logic [NUM_CH*32-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overrun,
  output logic                  busy
);

  if (NUM_CH < 1 || NUM_CH > 8 || SCK_HALF < 10 || SCK_HALF > 2000 ||
      AVG_LOG2 < 0 || AVG_LOG2 > 8) begin : g_param_check
    $error("hx711_multi_reader: parameter out of legal range");
  end

  localparam int HALF_W = $clog2(SCK_HALF);

  state_t              state, next_state;
  logic [HALF_W-1:0]   half_cnt;
  logic [4:0]          pulse_cnt;
  logic [4:0]          pulse_total;
  logic [NUM_CH-1:0]   dt_sync;
  logic signed [31:0]  sample [NUM_CH];
  logic                half_last;
  logic                all_ready;
  logic                start;
  logic                abort;
  logic                shift_en;
  logic                chan_clear;
  logic                done_wr;
  logic                sck_next;
  logic                busy_next;

  assign half_last  = (half_cnt == HALF_W'(SCK_HALF - 1));
  assign all_ready  = ~|dt_sync;
  assign chan_clear = start | abort;

  // Next-state and strobe decode; en low always wins and powers down
  always_comb begin
    next_state = state;
    start      = 1'b0;
    abort      = 1'b0;
    shift_en   = 1'b0;
    if (!en) begin
      next_state = PDOWN;
      abort      = (state != PDOWN);
    end else begin
      case (state)
        PDOWN:    next_state = WAIT_RDY;
        WAIT_RDY: if (all_ready) begin
                    next_state = SCK_HI;
                    start      = 1'b1;
                  end
        SCK_HI:   if (half_last) begin
                    next_state = SCK_LO;
                    shift_en   = (pulse_cnt < DATA_PULSES);
                  end
        SCK_LO:   if (half_last)
                    next_state = (pulse_cnt < pulse_total) ? SCK_HI : DONE;
        DONE:     next_state = WAIT_RDY;
        default:  next_state = PDOWN;
      endcase
    end
    sck_next  = (next_state == PDOWN) || (next_state == SCK_HI);
    busy_next = (next_state == SCK_HI) || (next_state == SCK_LO);
  end

  // State and registered pin outputs, so PD_SCK never glitches on decode
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PDOWN;
      hx711_sck <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      hx711_sck <= sck_next;
      busy      <= busy_next;
    end
  end

  // Phase timer, pulse counter and the gain latched at conversion start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_cnt    <= '0;
      pulse_cnt   <= '0;
      pulse_total <= PULSES_A128;
    end else begin
      if (en && (state == SCK_HI || state == SCK_LO) && !half_last)
        half_cnt <= half_cnt + 1'b1;
      else
        half_cnt <= '0;
      if (start) begin
        pulse_cnt   <= '0;
        pulse_total <= gain_pulses(gain_sel);
      end else if (state == SCK_HI && half_last) begin
        pulse_cnt <= pulse_cnt + 1'b1;
      end
    end
  end

`ifdef HX711_AVG_EN
  localparam int WIN_W = (AVG_LOG2 < 1) ? 1 : AVG_LOG2;

  logic [WIN_W-1:0] win_cnt;
  logic             win_last;
  logic             acc_clear;
  logic             acc_add;

  assign win_last  = (AVG_LOG2 == 0) ? 1'b1 : (win_cnt == {WIN_W{1'b1}});
  assign acc_clear = abort | (start && (gain_pulses(gain_sel) != pulse_total));
  assign acc_add   = (state == DONE);
  assign done_wr   = (state == DONE) && win_last;

  // Position within the averaging window; a gain change or abort restarts it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             win_cnt <= '0;
    else if (acc_clear)       win_cnt <= '0;
    else if (state == DONE)   win_cnt <= win_last ? '0 : win_cnt + 1'b1;
  end
`else
  assign done_wr = (state == DONE);
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    hx711_chan_shift
`ifdef HX711_AVG_EN
      #(.AVG_LOG2(AVG_LOG2))
`endif
      u_chan (
        .clk       (clk),
        .reset_n   (reset_n),
        .dt        (hx711_dt[k]),
        .shift_en  (shift_en),
        .clear     (chan_clear),
`ifdef HX711_AVG_EN
        .acc_add   (acc_add),
        .acc_clear (acc_clear),
        .win_last  (win_last),
`endif
        .dt_sync   (dt_sync[k]),
        .sample    (sample[k])
      );
  end

  // Output set with valid/ready; an unaccepted set is overwritten and flagged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (done_wr) begin
      for (int k = 0; k < NUM_CH; k++) out_data[32*k +: 32] <= sample[k];
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hx711_multi_reader.sv
// Directed bench for hx711_multi_reader with a behavioural HX711 model per
// channel. Define HX711_AVG_EN to exercise the averaging build instead.
`timescale 1ns/1ps
module tb_hx711_multi_reader;
  import hx711_pkg::*;

  localparam int NUM_CH   = 2;
  localparam int SCK_HALF = 10;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 en = 1'b0;
  logic [1:0]           gain_sel = 2'd0;
  logic [NUM_CH-1:0]    hx711_dt;
  logic                 hx711_sck;
  logic [NUM_CH*32-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic                 overrun;
  logic                 busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hx711_multi_reader #(.NUM_CH(NUM_CH), .SCK_HALF(SCK_HALF), .AVG_LOG2(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .gain_sel  (gain_sel),
    .hx711_dt  (hx711_dt),
    .hx711_sck (hx711_sck),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .busy      (busy)
  );

  // HX711 model: DOUT low when armed; each rising PD_SCK edge presents the
  // next bit MSB-first, and from the 25th edge DOUT returns high.
  logic [23:0]       mdl_word [NUM_CH];
  logic [NUM_CH-1:0] mdl_armed = '0;
  int                sck_count = 0;
  int                arm_base = 0;
  int                mdl_idx;

  always @(posedge hx711_sck) sck_count++;

  always_comb begin
    mdl_idx = sck_count - arm_base;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!mdl_armed[k])                   hx711_dt[k] = 1'b1;
      else if (mdl_idx == 0)               hx711_dt[k] = 1'b0;
      else if (mdl_idx >= 1 && mdl_idx <= 24) hx711_dt[k] = mdl_word[k][24 - mdl_idx];
      else                                 hx711_dt[k] = 1'b1;
    end
  end

  task automatic arm(input logic [23:0] w0, input logic [23:0] w1,
                     input logic [NUM_CH-1:0] which);
    mdl_word[0] = w0;
    mdl_word[1] = w1;
    arm_base    = sck_count;
    mdl_armed   = which;
  endtask

  function automatic int model_next_gain(input int pulses);
    return (pulses == 27) ? 2 : (pulses == 26) ? 1 : 0;
  endfunction

  // Waits (bounded) for one conversion; returns SCK-activity cycle count
  task automatic run_conv(output int busy_cyc, output bit ok);
    ok = 1'b0;
    busy_cyc = 0;
    for (int n = 0; n < 200 && !busy; n++) @(negedge clk);
    if (!busy) return;
    while (busy && busy_cyc < 2000) begin
      busy_cyc++;
      @(negedge clk);
    end
    if (busy) return;
    @(negedge clk);
    ok = 1'b1;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (hx711_sck !== 1'b1) begin miscompares++; $display("FAIL reset_sck: got %0b want 1", hx711_sck); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vectors++; if (out_data !== 64'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", out_data); end
    vectors++; if (dut.state !== PDOWN) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", dut.state, PDOWN); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (hx711_sck !== 1'b1) begin miscompares++; $display("FAIL pdown_sck: got %0b want 1", hx711_sck); end
    en = 1'b1;
    @(posedge clk); #1;
    vectors++; if (hx711_sck !== 1'b0 || dut.state !== WAIT_RDY) begin miscompares++; $display("FAIL wake: sck %0b state %0d want 0/%0d", hx711_sck, dut.state, WAIT_RDY); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc; bit ok;
    gain_sel = 2'd0;
    arm(24'h7FFFFF, 24'h800000, 2'b11);
    run_conv(cyc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL basic_timeout: got no completion want completion"); end
    vectors++; if (cyc !== 500) begin miscompares++; $display("FAIL basic_cycles: got %0d want 500", cyc); end
    vectors++; if (sck_count - arm_base !== 25) begin miscompares++; $display("FAIL basic_pulses: got %0d want 25", sck_count - arm_base); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %0b want 1", out_valid); end
    vectors++; if (out_data !== {32'hFF800000, 32'h007FFFFF}) begin miscompares++; $display("FAIL basic_data: got %h want ff800000007fffff", out_data); end
    vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL basic_overrun: got %0b want 0", overrun); end
    accept();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL handshake_clear: got %0b want 0", out_valid); end
    vectors++; if (out_data !== {32'hFF800000, 32'h007FFFFF}) begin miscompares++; $display("FAIL handshake_hold: got %h want ff800000007fffff", out_data); end
  endtask

  task automatic test_gain();
    logic [1:0]  gs [3] = '{2'd1, 2'd2, 2'd3};
    int          ep [3] = '{26, 27, 25};
    logic [23:0] w0 [3] = '{24'h000001, 24'h000001, 24'hC00000};
    logic [23:0] w1 [3] = '{24'hFFFFFF, 24'h3FFFFF, 24'h800001};
    logic [63:0] exp_data;
    int cyc; bit ok; int pulses; int exp_gain;
    for (int i = 0; i < 3; i++) begin
      gain_sel = gs[i];
      arm(w0[i], w1[i], 2'b11);
      run_conv(cyc, ok);
      pulses   = sck_count - arm_base;
      exp_data = {{8{w1[i][23]}}, w1[i], {8{w0[i][23]}}, w0[i]};
      exp_gain = (gs[i] == 2'd3) ? 0 : int'(gs[i]);
      vectors++; if (!ok) begin miscompares++; $display("FAIL gain%0d_timeout: got no completion want completion", i); end
      vectors++; if (pulses !== ep[i]) begin miscompares++; $display("FAIL gain%0d_pulses: got %0d want %0d", i, pulses, ep[i]); end
      vectors++; if (cyc !== ep[i] * 2 * SCK_HALF) begin miscompares++; $display("FAIL gain%0d_cycles: got %0d want %0d", i, cyc, ep[i] * 2 * SCK_HALF); end
      vectors++; if (model_next_gain(pulses) !== exp_gain) begin miscompares++; $display("FAIL gain%0d_mode: got %0d want %0d", i, model_next_gain(pulses), exp_gain); end
      vectors++; if (out_data !== exp_data) begin miscompares++; $display("FAIL gain%0d_data: got %h want %h", i, out_data, exp_data); end
      accept();
    end
    gain_sel = 2'd0;
  endtask

  task automatic test_overrun();
    int cyc; bit ok;
    arm(24'h123456, 24'h000000, 2'b11);
    run_conv(cyc, ok);
    vectors++; if (!ok || out_valid !== 1'b1 || overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_first: ok %0b valid %0b overrun %0b want 1/1/0", ok, out_valid, overrun); end
    arm(24'hABCDEF, 24'h400000, 2'b11);
    run_conv(cyc, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ovr_timeout: got no completion want completion"); end
    vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_flag: got %0b want 1", overrun); end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ovr_valid: got %0b want 1", out_valid); end
    vectors++; if (out_data !== {32'h00400000, 32'hFFABCDEF}) begin miscompares++; $display("FAIL ovr_data: got %h want 00400000ffabcdef", out_data); end
    accept();
    repeat (3) @(negedge clk);
    vectors++; if (overrun !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL ovr_sticky: overrun %0b valid %0b want 1/0", overrun, out_valid); end
  endtask

  task automatic test_abort();
    int cyc; bit ok; int n;
    arm(24'h555555, 24'h2AAAAA, 2'b11);
    n = 0;
    while ((sck_count - arm_base) < 12 && n < 1000) begin n++; @(negedge clk); end
    vectors++; if ((sck_count - arm_base) !== 12) begin miscompares++; $display("FAIL abort_reach12: got %0d want 12", sck_count - arm_base); end
    en = 1'b0;
    @(posedge clk); #1;
    vectors++; if (hx711_sck !== 1'b1) begin miscompares++; $display("FAIL abort_sck: got %0b want 1", hx711_sck); end
    vectors++; if (dut.state !== PDOWN || busy !== 1'b0) begin miscompares++; $display("FAIL abort_state: state %0d busy %0b want %0d/0", dut.state, busy, PDOWN); end
    repeat (5) @(negedge clk);
    vectors++; if (out_data !== {32'h00400000, 32'hFFABCDEF} || out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_hold: data %h valid %0b want 00400000ffabcdef/0", out_data, out_valid); end
    en = 1'b1;
    arm(24'h0F0F0F, 24'hF0F0F0, 2'b11);
    run_conv(cyc, ok);
    vectors++; if (!ok || cyc !== 500 || (sck_count - arm_base) !== 25) begin miscompares++; $display("FAIL reenable_conv: ok %0b cycles %0d pulses %0d want 1/500/25", ok, cyc, sck_count - arm_base); end
    vectors++; if (out_data !== {32'hFFF0F0F0, 32'h000F0F0F}) begin miscompares++; $display("FAIL reenable_data: got %h want fff0f0f0000f0f0f", out_data); end
    accept();
  endtask

  task automatic test_stuck();
    int busy_seen;
    busy_seen = 0;
    arm(24'h000000, 24'h000000, 2'b01);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    vectors++; if ((sck_count - arm_base) !== 0) begin miscompares++; $display("FAIL stuck_pulses: got %0d want 0", sck_count - arm_base); end
    vectors++; if (busy_seen !== 0) begin miscompares++; $display("FAIL stuck_busy: got %0d busy cycles want 0", busy_seen); end
    vectors++; if (dut.state !== WAIT_RDY) begin miscompares++; $display("FAIL stuck_state: got %0d want %0d", dut.state, WAIT_RDY); end
  endtask

`ifdef HX711_AVG_EN
  task automatic test_avg();
    logic [23:0] s0 [4] = '{24'd100, 24'd104, 24'hFFFFFC, 24'd0};
    int cyc; bit ok;
    for (int i = 0; i < 4; i++) begin
      arm(s0[i], 24'hFFFFF8, 2'b11);
      run_conv(cyc, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL avg%0d_timeout: got no completion want completion", i); end
      if (i < 3) begin
        vectors++; if (out_valid !== 1'b0 || out_data !== 64'h0) begin miscompares++; $display("FAIL avg%0d_early: valid %0b data %h want 0/0", i, out_valid, out_data); end
      end
    end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL avg_valid: got %0b want 1", out_valid); end
    vectors++; if (out_data !== {32'hFFFFFFF8, 32'h00000032}) begin miscompares++; $display("FAIL avg_data: got %h want fffffff800000032", out_data); end
    accept();
  endtask
`endif

  initial begin
    test_reset();
`ifdef HX711_AVG_EN
    test_avg();
`else
    test_basic();
    test_gain();
    test_overrun();
    test_abort();
    test_stuck();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hx711_multi_reader.md
HX711_MULTI_READER -- requirements
Module: hx711_multi_reader

Interface
REQ-001 Parameter NUM_CH, default 2: number of HX711 channels, legal range 1..8.
REQ-002 Parameter SCK_HALF, default 25: clk cycles per SCK high phase and per SCK low phase, legal range 10..2000.
REQ-003 Parameter AVG_LOG2, default 2: log2 of the averaging window, used only with HX711_AVG_EN.
REQ-004 Port clk, input, 1: single system clock; all logic is in this domain.
REQ-005 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port en, input, 1: 1 = run conversions; 0 = HX711 power-down.
REQ-007 Port gain_sel, input, 2: selects the next conversion's mode; 0 = A/128 (25 pulses), 1 = B/32 (26 pulses), 2 = A/64 (27 pulses), 3 = reserved and treated as 0.
REQ-008 Port hx711_dt, input, NUM_CH: per-channel DOUT; asynchronous to clk.
REQ-009 Port hx711_sck, output, 1: shared PD_SCK to all channels.
REQ-010 Port out_data, output, NUM_CH*32: channel k occupies bits [32k+31:32k]; each value is a sign-extended sample.
REQ-011 Port out_valid, output, 1: out_data holds a complete sample set.
REQ-012 Port out_ready, input, 1: consumer accepts the sample set.
REQ-013 Port overrun, output, 1: sticky; a sample set was dropped.
REQ-014 Port busy, output, 1: high in the SCK_HI and SCK_LO states.

Function
REQ-015 Each hx711_dt bit shall pass through a 2-FF synchronizer; the state machine uses only the synchronized values.
REQ-016 The FSM states shall be PDOWN, WAIT_RDY, SCK_HI, SCK_LO and DONE.
REQ-017 PDOWN: hx711_sck=1; the FSM moves to WAIT_RDY, with hx711_sck=0, on the first cycle en=1.
REQ-018 WAIT_RDY: the FSM moves to SCK_HI when all synchronized dt bits are 0; gain_sel is latched into pulse_total (25/26/27) on that transition.
REQ-019 SCK_HI holds hx711_sck=1 for exactly SCK_HALF cycles.
REQ-020 On the last cycle of SCK_HI, for pulse index 0..23, each channel's dt bit shall shift MSB-first into its 24-bit shift register; pulses 24..26 sample nothing.
REQ-021 SCK_LO holds hx711_sck=0 for SCK_HALF cycles, then goes to SCK_HI if pulses sent < pulse_total, otherwise to DONE.
REQ-022 A conversion shall be exactly pulse_total*2*SCK_HALF cycles from leaving WAIT_RDY to entering DONE.
REQ-023 DONE lasts one cycle: each 24-bit value is sign-extended (bit 23 replicated) to 32 bits and written to the output register.
REQ-024 On the DONE write, out_valid=1 from the next cycle, and the FSM returns to WAIT_RDY.
REQ-025 Handshake: the sample set is transferred when out_valid&&out_ready; out_valid clears the next cycle unless DONE writes in the same cycle, in which case out_valid stays 1 with the new data.
REQ-026 If DONE occurs while out_valid=1 and out_ready=0, the new set overwrites out_data, out_valid stays 1, and overrun is set.
REQ-027 overrun clears only on reset.
REQ-028 en falling in any state shall, on the next cycle, abort the conversion, discard the partial shift registers, enter PDOWN and drive hx711_sck=1; out_data and out_valid are kept.
REQ-029 out_data changes only on DONE writes and on reset.

Reset
REQ-030 Asserting reset_n=0 asynchronously forces the state to PDOWN and drives these values: hx711_sck=1, out_valid=0, overrun=0, busy=0, out_data=0.
REQ-031 Reset also clears the counters, the synchronizers and pulse_total (to 25).
REQ-032 Reset release shall be glitch-free; the first transition is allowed one cycle after reset_n rises.

Configuration
REQ-033 HX711_AVG_EN defined: each channel keeps a (24+AVG_LOG2)-bit signed accumulator.
REQ-034 With HX711_AVG_EN, DONE updates the output register only every 2^AVG_LOG2 conversions, with the accumulator arithmetic-shifted right by AVG_LOG2 and sign-extended to 32 bits; the accumulators then clear.
REQ-035 With HX711_AVG_EN, a change of latched gain_sel versus the previous conversion, or an en abort, clears the accumulators and the window count.
REQ-036 HX711_AVG_EN undefined: every conversion is output directly and no accumulator logic is synthesized.

Structure
REQ-037 Package hx711_pkg shall hold the state enum, the gain mode enum, the pulse-count constants (25/26/27), and the function mapping gain_sel to the pulse count.
REQ-038 Sub-module hx711_chan_shift shall be instantiated NUM_CH times, containing the synchronizer, the 24-bit shift register and, under HX711_AVG_EN, the accumulator; the FSM stays in the top.

Verification
REQ-039 NUM_CH=2, SCK_HALF=10, gain_sel=0, models return 0x7FFFFF and 0x800000 -> 25 SCK pulses, out_data = {0xFF800000, 0x007FFFFF}, out_valid after 500 cycles of SCK activity.
REQ-040 gain_sel=2, model returns 0x000001 -> exactly 27 pulses, and the model reports A/64 selected for the next conversion.
REQ-041 out_ready held at 0 across two conversions -> overrun=1, out_data holds the second set, out_valid stays 1.
REQ-042 en driven to 0 at pulse 12 -> hx711_sck=1 on the next cycle, FSM in PDOWN, out_data unchanged; re-enable -> a clean 25-pulse conversion.
REQ-043 One channel's dt held high -> no SCK pulses and busy=0 indefinitely.
REQ-044 With HX711_AVG_EN and AVG_LOG2=2, samples 100, 104, -4, 0 -> a single output update of 50, after the 4th conversion.
